// File: rtl/bcd_pkg.sv
// Shared BCD definitions: converter FSM encoding, nibble adjust constants,
// BCD adder correction constants and an elaboration-time range helper.
package bcd_pkg;

   localparam int NIBBLE_W = 4;

   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ_VAL    = 4'd3;

   localparam logic [4:0] BCD_ADD_LIMIT  = 5'd9;
   localparam logic [3:0] BCD_ADD_CORR   = 4'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } bcd_state_t;

   // 10^n, used to prove at elaboration that DIGITS covers 2^BIN_W - 1
   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble adjust: adds 3 when the digit is 5 or more, so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] digit_adj
);

   // Pre-adjust digits are 0..9, so the result never exceeds 12
   always_comb begin
      digit_adj = digit;
      if (digit >= BCD_ADJ_THRESH) begin
         digit_adj = digit + BCD_ADJ_VAL;
      end else begin
         digit_adj = digit;
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, with a
// start/busy/done handshake and a held BCD result register.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [BIN_W-1:0]             bin,
   output logic                         busy,
   output logic                         done,
   output logic [NIBBLE_W*DIGITS-1:0]   bcd
);

   localparam int BCD_W = NIBBLE_W * DIGITS;
   localparam int SH_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   if ((BIN_W < 1) || (pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1))) begin : g_range_check
      $error("bin_to_bcd_seq: DIGITS=%0d cannot hold a %0d-bit value", DIGITS, BIN_W);
   end

   bcd_state_t        state;
   logic [SH_W-1:0]   shreg;
   logic [SH_W-1:0]   adjusted;
   logic [SH_W-1:0]   shifted;
   logic [CNT_W-1:0]  cnt;

   assign adjusted[BIN_W-1:0] = shreg[BIN_W-1:0];

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit     (shreg   [BIN_W + NIBBLE_W*g +: NIBBLE_W]),
         .digit_adj (adjusted[BIN_W + NIBBLE_W*g +: NIBBLE_W])
      );
   end

   assign shifted = adjusted << 1;

   // Control FSM, shift register, bit counter and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         bcd   <= '0;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shreg <= {{BCD_W{1'b0}}, bin};
                  cnt   <= CNT_W'(BIN_W);
                  busy  <= 1'b1;
                  state <= CONV;
               end else begin
                  state <= IDLE;
               end
            end
            CONV: begin
               shreg <= shifted;
               cnt   <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  bcd   <= shifted[SH_W-1:BIN_W];
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end else begin
                  state <= CONV;
               end
            end
            DONE: begin
               done <= 1'b0;
               // back-to-back load straight from DONE, no idle gap
               if (start) begin
                  shreg <= {{BCD_W{1'b0}}, bin};
                  cnt   <= CNT_W'(BIN_W);
                  busy  <= 1'b1;
                  state <= CONV;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq (BIN_W=8, DIGITS=3).
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  bin;
   logic        busy;
   logic        done;
   logic [11:0] bcd;

   int tests = 0;
   int fails = 0;

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   always #5 clk = ~clk;

   // drive start for one edge; returns 1ns after the accepting edge
   task automatic launch(input logic [7:0] v);
      start = 1'b1;
      bin   = v;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // edges until done is seen; -1 when the bound expires
   task automatic wait_done(output int lat);
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; bin = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({busy, done, bcd} !== 14'd0) begin
         fails++;
         $display("FAIL reset_state: busy=%b done=%b bcd=%h, required 0 0 000", busy, done, bcd);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_zero();
      int lat;
      launch(8'd0);
      wait_done(lat);
      tests++;
      if (lat != 8) begin
         fails++;
         $display("FAIL zero_latency: got %0d, required 8", lat);
      end
      tests++;
      if (bcd !== 12'h000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL zero_result: bcd=%h busy=%b, required 000 0", bcd, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_max();
      int bad_busy;
      bad_busy = 0;
      launch(8'd255);
      for (int c = 1; c <= 7; c++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
         @(posedge clk); #1;
      end
      if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
      tests++;
      if (bad_busy != 0) begin
         fails++;
         $display("FAIL max_busy: %0d busy/done errors during conversion, required 0", bad_busy);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b1 || busy !== 1'b0 || bcd !== 12'h255) begin
         fails++;
         $display("FAIL max_done: done=%b busy=%b bcd=%h, required 1 0 255", done, busy, bcd);
      end
      repeat (3) begin @(posedge clk); #1; end
      tests++;
      if (done !== 1'b0 || bcd !== 12'h255) begin
         fails++;
         $display("FAIL max_hold: done=%b bcd=%h, required 0 255", done, bcd);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      launch(8'd99);
      wait_done(lat);
      tests++;
      if (lat != 8 || bcd !== 12'h099) begin
         fails++;
         $display("FAIL b2b_first: lat=%0d bcd=%h, required 8 099", lat, bcd);
      end
      launch(8'd37);
      tests++;
      if (busy !== 1'b1 || done !== 1'b0 || bcd !== 12'h099) begin
         fails++;
         $display("FAIL b2b_reload: busy=%b done=%b bcd=%h, required 1 0 099", busy, done, bcd);
      end
      wait_done(lat);
      tests++;
      if (lat + 1 != 9 || bcd !== 12'h037) begin
         fails++;
         $display("FAIL b2b_second: spacing=%0d bcd=%h, required 9 037", lat + 1, bcd);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_ignore_start();
      int done_at;
      int extra;
      done_at = -1;
      extra = 0;
      launch(8'd200);
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (c == 3) begin start = 1'b1; bin = 8'd15; end
         if (c == 4) begin start = 1'b0; end
         if (done) begin done_at = c; break; end
      end
      tests++;
      if (done_at != 8 || bcd !== 12'h200) begin
         fails++;
         $display("FAIL ignore_start: done_at=%0d bcd=%h, required 8 200", done_at, bcd);
      end
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) extra++;
      end
      tests++;
      if (extra != 0 || bcd !== 12'h200) begin
         fails++;
         $display("FAIL ignore_extra: %0d stray busy/done cycles, bcd=%h, required 0 200", extra, bcd);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      int lat;
      seen = 0;
      launch(8'd128);
      repeat (4) @(posedge clk);
      #4;
      rst = 1'b1;
      #1;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
         fails++;
         $display("FAIL reset_mid: busy=%b done=%b bcd=%h, required 0 0 000", busy, done, bcd);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) seen++;
      end
      tests++;
      if (seen != 0) begin
         fails++;
         $display("FAIL reset_no_done: %0d busy/done cycles after reset, required 0", seen);
      end
      launch(8'd128);
      wait_done(lat);
      tests++;
      if (lat != 8 || bcd !== 12'h128) begin
         fails++;
         $display("FAIL reset_recover: lat=%0d bcd=%h, required 8 128", lat, bcd);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sweep();
      int lat;
      logic [11:0] exp;
      for (int v = 0; v < 256; v++) begin
         exp = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
         launch(8'(v));
         wait_done(lat);
         tests++;
         if (lat != 8 || bcd !== exp) begin
            fails++;
            $display("FAIL sweep_%0d: lat=%0d bcd=%h, required 8 %h", v, lat, bcd, exp);
         end
         tests++;
         if (bcd[3:0] > 4'd9 || bcd[7:4] > 4'd9 || bcd[11:8] > 4'd9) begin
            fails++;
            $display("FAIL sweep_digit_%0d: bcd=%h has a nibble above 9", v, bcd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_max();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double-dabble), one input bit per clock.
- Sits directly upstream of the BCD adder and produces the packed BCD operand digits it consumes.
- A start/busy/done handshake lets a controller load a binary value, then read the held BCD result.

Parameters:
- BIN_W, 8, width of the binary input. Must be >= 1.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1, i.e. no overflow possible; an elaboration-time check enforces this.

Ports:
- clk  in  1  clock, rising-edge active
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a conversion of bin; sampled on the rising clk edge
- bin  in  BIN_W  unsigned binary value, sampled when start is accepted
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when bcd has been updated
- bcd  out  4*DIGITS  packed BCD result; digit i occupies bits [4i+3:4i], digit 0 is the units digit

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, bcd=0, shift register=0, bit counter=0.
- FSM states and transitions:
  - IDLE: start=1 -> load, go to CONV. start=0 -> stay in IDLE.
  - CONV: one conversion step per clk edge.
  - DONE: single cycle, then IDLE; start=1 -> load, go to CONV (back-to-back allowed).
- Load, at edge k where start is accepted:
  - Shift register becomes {DIGITS*4 zeros, bin}.
  - Bit counter becomes BIN_W.
  - busy=1 from edge k onward.
- CONV step, each edge:
  - Every BCD nibble of the shift register with value >= 5 gets +3 (combinational, all nibbles in parallel).
  - The adjusted register is then shifted left by 1.
  - The counter decrements.
- Completion, on the step where the counter goes 1->0, i.e. edge k+BIN_W:
  - The bcd register loads the upper 4*DIGITS bits of the post-shift value.
  - done=1, busy=0, state=DONE.
  - Latency from the start-accepting edge to done: exactly BIN_W cycles.
- done is high for exactly one cycle, then falls at edge k+BIN_W+1 unless a new conversion completes then (impossible, since BIN_W >= 1).
- bcd holds its value until the next completion. It does not change during CONV.
- start while in CONV is ignored: no restart, bin is not re-sampled, no error flag.
- start in DONE is accepted (back-to-back conversions). Resulting done pulses are BIN_W+1 cycles apart.
- Reset asserted mid-conversion: immediate return to reset values. No done pulse; the partial result is discarded.
- Arithmetic: a nibble adjust result never exceeds 4'd12 (pre-adjust max 9), so no nibble overflow and no carry between nibbles. Every bcd digit is always 0..9.
- bin=0 yields bcd=0 with the normal latency; no short-circuit.

Decomposition:
- Shared package bcd_pkg:
  - FSM state encoding (IDLE, CONV, DONE).
  - BCD_ADJ_THRESH=4'd5 and BCD_ADJ_VAL=4'd3.
  - NIBBLE_W=4.
  - Also reused by the BCD adder's +6 correction constants.
- Sub-module bcd_digit_adj: combinational, 4-bit in/out, adds 3 when in >= 5. Instantiated DIGITS times via generate.
- Top holds the FSM, counter, shift register and output register.

Test Plan (BIN_W=8, DIGITS=3):
- Reset, then start with bin=8'd0 -> done at start edge+8, bcd=12'h000, busy low after completion.
- start with bin=8'd255 -> busy high for 8 cycles, done pulse 1 cycle, bcd=12'h255, held afterwards.
- start with bin=8'd99, then bin=8'd37 asserted in the DONE cycle -> bcd=12'h099, then 12'h037 exactly 9 cycles later. Two done pulses, no IDLE gap.
- start with bin=8'd200; at cycle 3 drive start=1 with bin=8'd15 -> second start ignored; bcd=12'h200 at edge+8, no extra done.
- start with bin=8'd128; assert rst asynchronously at cycle 4 (mid-cycle) -> busy, done, bcd drop to 0 immediately, no done pulse. After release, bin=8'd128 converts to 12'h128.
- Exhaustive sweep bin=0..255 -> every bcd equals the decimal of bin, every nibble <= 9, done latency always 8.
